md_sequencer: RTL
=================

Name: md_sequencer

Overview:
- Multi-cycle controller for the RV32M multiply/divide class (opcode 0110011, funct7 0000001) issued in the EX stage.
- Captures the forwarded rs1 and rs2 operands and runs a radix-2 iterative shift-add (MUL*) or shift-subtract (DIV*/REM*) engine.
- Holds the pipeline with a stall until the result is ready, then presents the result for the EX/MEM register.
- Sits beside the ALU. The EX result mux selects o_result when o_done is 1.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- CNT_W, $clog2(XLEN), iteration counter width; localparam, not overridable.

Ports:
- i_clk  input  1  clock
- i_rst_n  input  1  asynchronous active-low reset
- i_valid  input  1  EX holds an M-extension instruction; held stable while o_stall=1
- i_funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- i_rs1_val  input  XLEN  forwarded rs1 operand, sampled only in the accept cycle
- i_rs2_val  input  XLEN  forwarded rs2 operand, sampled only in the accept cycle
- i_flush  input  1  branch/trap flush of EX; aborts the operation
- o_stall  output  1  freeze IF/ID/EX and hold the EX/MEM bubble
- o_done  output  1  one-cycle pulse; o_result is valid
- o_result  output  XLEN  final rd value, 0 when o_done=0

Behaviour:
- Reset values (async): state IDLE, o_stall=0, o_done=0, o_result=0, counter=0, all engine registers 0.
- IDLE:
  - i_valid=1 and i_flush=0 gives o_stall=1 in the same cycle (combinational). Operands, funct3 and signedness flags are captured at the clock edge.
  - DIV* with divisor 0, or DIV/REM with overflow (rs1=0x80000000, rs2=0xFFFFFFFF) goes to DONE. Otherwise go to BUSY with the counter set to XLEN-1.
- BUSY (o_stall=1):
  - One iteration per cycle on the absolute values of the operands.
  - MUL: 2*XLEN accumulator.
  - DIV: remainder and quotient shift register.
  - Counter decrements. At 0 go to FIX.
- FIX (o_stall=1):
  - Apply sign correction.
  - Product is negated if exactly one signed operand is negative.
  - Quotient is negated if the signs differ.
  - Remainder takes the sign of the dividend.
  - Select the low or high word. Go to DONE.
- DONE: o_done=1, o_stall=0 so the pipeline advances at this edge. Next state is IDLE. i_valid is ignored in DONE.
- Latency:
  - Normal operation: accept at T, o_done at T+XLEN+2 (T+34); 35 cycles of occupancy.
  - Special cases: accept at T, o_done at T+1.
- Special results, required exactly:
  - DIV/DIVU by 0 returns 0xFFFFFFFF.
  - REM/REMU by 0 returns rs1.
  - DIV overflow returns 0x80000000; REM overflow returns 0.
- MULHSU: rs1 is signed, rs2 is unsigned. MULHU, DIVU and REMU treat both operands as unsigned.
- i_flush has priority in every state:
  - Next state is IDLE, with o_done=0 and o_stall=0 in the flush cycle.
  - No result is produced.
  - i_valid in a flush cycle is not accepted.
- Reset mid-operation: immediate return to reset values. A partial result is never emitted.
- i_valid deasserting in BUSY without a flush is a protocol error. Behaviour is undefined; a bench assertion flags it.

Optional Feature:
- Macro: MD_RESULT_REUSE_EN.
- When defined:
  - Keep the last completed operands, a signedness class (DIV/REM and DIVU/REMU pair; MULH/MUL and MULHU/MUL pair) and both result halves (quotient and remainder, or high and low product).
  - A new accept with identical operands and a matching class completes via DONE at T+1 from the stored half.
  - Reuse state is invalidated by reset, by flush during BUSY/FIX, and by any completed operation of a different class.
- When undefined: no reuse registers exist, and every non-special operation takes 35 cycles.

Decomposition:
- Package md_pkg:
  - md_op_e enum for the funct3 codes
  - md_state_e {IDLE, BUSY, FIX, DONE}
  - OPCODE_R and FUNCT7_MULDIV constants
  - DIV_ZERO_Q = '1
- One natural sub-module, md_iter_engine: shift-add and shift-subtract datapath with a start/step/load interface. md_sequencer owns the FSM, counter, special-case detection and sign fix.

Test Plan:
- MUL 7 × -3 (0x00000007, 0xFFFFFFFD) → o_done at T+34, o_result=0xFFFFFFEB; o_stall high T..T+33.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIVU 5/0 → 0xFFFFFFFF at T+1; REM 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000 at T+1; REM of the same → 0.
- Accept DIV, assert i_flush at T+10 → o_stall=0 that cycle, no o_done, IDLE at T+11; a new MUL 3×4 at T+11 → 12 at T+45. Async reset at T+5 → all outputs 0 immediately.
- With MD_RESULT_REUSE_EN: DIV 100/7, then REM 100/7 → 2 at T+1; then REM 100/8 → full 35-cycle path, result 4.

Source files
------------

// File: rtl/md_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
// Optional result reuse is enabled with MD_RESULT_REUSE_EN.
package md_pkg;

  localparam logic [6:0]  OPCODE_R      = 7'b0110011;
  localparam logic [6:0]  FUNCT7_MULDIV = 7'b0000001;
  localparam logic [31:0] DIV_ZERO_Q    = '1;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } md_state_e;

  // Signedness class: ops in one class share both stored result halves
  typedef enum logic [2:0] {
    CLS_DIVS  = 3'd0,
    CLS_DIVU  = 3'd1,
    CLS_MULS  = 3'd2,
    CLS_MULSU = 3'd3,
    CLS_MULU  = 3'd4
  } md_cls_e;

  function automatic logic is_muldiv(input logic [6:0] opcode, input logic [6:0] funct7);
    return (opcode == OPCODE_R) && (funct7 == FUNCT7_MULDIV);
  endfunction

  function automatic logic sel_hi(input md_op_e op);
    case (op)
      OP_MUL, OP_DIV, OP_DIVU: sel_hi = 1'b0;
      default:                 sel_hi = 1'b1;
    endcase
  endfunction

  function automatic md_cls_e op_class(input md_op_e op);
    case (op)
      OP_DIV, OP_REM:   op_class = CLS_DIVS;
      OP_DIVU, OP_REMU: op_class = CLS_DIVU;
      OP_MUL, OP_MULH:  op_class = CLS_MULS;
      OP_MULHSU:        op_class = CLS_MULSU;
      default:          op_class = CLS_MULU;
    endcase
  endfunction

endpackage

// File: rtl/md_iter_engine.sv
// Radix-2 datapath on unsigned magnitudes: shift-add multiply into {hi,lo},
// restoring divide with remainder in hi and quotient shifted into lo.
module md_iter_engine #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_load,
  input  logic            i_step,
  input  logic            i_is_div,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic [XLEN-1:0] o_hi,
  output logic [XLEN-1:0] o_lo
);

  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_b;
  logic [XLEN:0]   w_mul_sum;
  logic [XLEN:0]   w_div_part;
  logic [XLEN+1:0] w_div_diff;

  // One iteration of each algorithm; the diff sign bit decides the quotient bit
  always_comb begin
    w_mul_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(XLEN+1){1'b0}});
    w_div_part = {r_hi, r_lo[XLEN-1]};
    w_div_diff = {1'b0, w_div_part} - {2'b00, r_b};
  end

  // Operand load and per-cycle iteration
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hi <= {XLEN{1'b0}};
      r_lo <= {XLEN{1'b0}};
      r_b  <= {XLEN{1'b0}};
    end else if (i_load) begin
      r_hi <= {XLEN{1'b0}};
      r_lo <= i_a;
      r_b  <= i_b;
    end else if (i_step) begin
      if (i_is_div) begin
        if (!w_div_diff[XLEN+1]) begin
          r_hi <= w_div_diff[XLEN-1:0];
          r_lo <= {r_lo[XLEN-2:0], 1'b1};
        end else begin
          r_hi <= w_div_part[XLEN-1:0];
          r_lo <= {r_lo[XLEN-2:0], 1'b0};
        end
      end else begin
        {r_hi, r_lo} <= {w_mul_sum, r_lo[XLEN-1:1]};
      end
    end
  end

  assign o_hi = r_hi;
  assign o_lo = r_lo;

endmodule

// File: rtl/md_sequencer.sv
// RV32M multi-cycle controller: FSM, special-case detection and sign fix.
// Optional last-result reuse is compiled in with MD_RESULT_REUSE_EN.
module md_sequencer
  import md_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_rs1_val,
  input  logic [XLEN-1:0] i_rs2_val,
  input  logic            i_flush,
  output logic            o_stall,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);

  localparam int              CNT_W    = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN-1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e         r_state, w_next;
  md_op_e            r_op, w_op;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_is_div, r_neg_res, r_neg_rem;
  logic [XLEN-1:0]   r_result;
  logic              w_accept, w_stall, w_load, w_step;
  logic              w_a_neg, w_b_neg, w_div0, w_ovf, w_special, w_hit;
  logic [XLEN-1:0]   w_a_abs, w_b_abs, w_special_val, w_hit_val;
  logic [XLEN-1:0]   w_eng_hi, w_eng_lo, w_q_fix, w_r_fix, w_fix_hi, w_fix_lo, w_fix_val;
  logic [2*XLEN-1:0] w_prod_fix;

  // Decode of the instruction presented in IDLE: signs, magnitudes, special cases
  always_comb begin
    w_op = md_op_e'(i_funct3);
    case (w_op)
      OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
        w_a_neg = i_rs1_val[XLEN-1];
        w_b_neg = i_rs2_val[XLEN-1];
      end
      OP_MULHSU: begin
        w_a_neg = i_rs1_val[XLEN-1];
        w_b_neg = 1'b0;
      end
      default: begin
        w_a_neg = 1'b0;
        w_b_neg = 1'b0;
      end
    endcase
    w_a_abs   = w_a_neg ? (ZERO - i_rs1_val) : i_rs1_val;
    w_b_abs   = w_b_neg ? (ZERO - i_rs2_val) : i_rs2_val;
    w_div0    = i_funct3[2] && (i_rs2_val == ZERO);
    w_ovf     = ((w_op == OP_DIV) || (w_op == OP_REM)) &&
                (i_rs1_val == INT_MIN) && (i_rs2_val == ALL_ONES);
    w_special = w_div0 || w_ovf;
    if (w_div0) begin
      w_special_val = i_funct3[1] ? i_rs1_val : DIV_ZERO_Q;
    end else begin
      w_special_val = i_funct3[1] ? ZERO : INT_MIN;
    end
    w_accept = (r_state == IDLE) && i_valid && !i_flush;
  end

  md_iter_engine #(.XLEN(XLEN)) u_engine (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_load   (w_load),
    .i_step   (w_step),
    .i_is_div (r_is_div),
    .i_a      (w_a_abs),
    .i_b      (w_b_abs),
    .o_hi     (w_eng_hi),
    .o_lo     (w_eng_lo)
  );

  // Sign correction of the magnitude result and low/high word selection
  always_comb begin
    w_prod_fix = r_neg_res ? ({(2*XLEN){1'b0}} - {w_eng_hi, w_eng_lo}) : {w_eng_hi, w_eng_lo};
    w_q_fix    = r_neg_res ? (ZERO - w_eng_lo) : w_eng_lo;
    w_r_fix    = r_neg_rem ? (ZERO - w_eng_hi) : w_eng_hi;
    if (r_is_div) begin
      w_fix_hi = w_r_fix;
      w_fix_lo = w_q_fix;
    end else begin
      w_fix_hi = w_prod_fix[2*XLEN-1:XLEN];
      w_fix_lo = w_prod_fix[XLEN-1:0];
    end
    w_fix_val = sel_hi(r_op) ? w_fix_hi : w_fix_lo;
  end

  // Next-state and control; flush overrides every state
  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    w_load  = 1'b0;
    w_step  = 1'b0;
    if (i_flush) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_valid) begin
            w_stall = 1'b1;
            if (w_special || w_hit) begin
              w_next = DONE;
            end else begin
              w_next = BUSY;
              w_load = 1'b1;
            end
          end else begin
            w_next = IDLE;
          end
        end
        BUSY: begin
          w_stall = 1'b1;
          w_step  = 1'b1;
          if (r_cnt == CNT_ZERO) begin
            w_next = FIX;
          end else begin
            w_next = BUSY;
          end
        end
        FIX: begin
          w_stall = 1'b1;
          w_next  = DONE;
        end
        DONE:    w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  // State, counter, captured op flags and the result register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_op      <= OP_MUL;
      r_cnt     <= CNT_ZERO;
      r_is_div  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_result  <= ZERO;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op      <= w_op;
        r_is_div  <= i_funct3[2];
        r_neg_res <= w_a_neg ^ w_b_neg;
        r_neg_rem <= w_a_neg;
        r_cnt     <= CNT_LAST;
        r_result  <= w_special ? w_special_val : w_hit_val;
      end
      if ((r_state == BUSY) && (r_cnt != CNT_ZERO)) begin
        r_cnt <= r_cnt - CNT_ONE;
      end
      if ((r_state == FIX) && !i_flush) begin
        r_result <= w_fix_val;
      end
    end
  end

`ifdef MD_RESULT_REUSE_EN
  logic            r_rv_valid;
  md_cls_e         r_rv_cls;
  logic [XLEN-1:0] r_rv_a, r_rv_b, r_rv_hi, r_rv_lo, r_a_raw, r_b_raw;

  // MUL only needs the low product word, which MULHU also leaves behind
  always_comb begin
    w_hit = r_rv_valid && !w_special &&
            (i_rs1_val == r_rv_a) && (i_rs2_val == r_rv_b) &&
            ((op_class(w_op) == r_rv_cls) || ((w_op == OP_MUL) && (r_rv_cls == CLS_MULU)));
    w_hit_val = sel_hi(w_op) ? r_rv_hi : r_rv_lo;
  end

  // Last completed operands and both corrected result halves
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rv_valid <= 1'b0;
      r_rv_cls   <= CLS_DIVS;
      r_rv_a     <= ZERO;
      r_rv_b     <= ZERO;
      r_rv_hi    <= ZERO;
      r_rv_lo    <= ZERO;
      r_a_raw    <= ZERO;
      r_b_raw    <= ZERO;
    end else begin
      if (w_accept) begin
        r_a_raw <= i_rs1_val;
        r_b_raw <= i_rs2_val;
      end
      if (i_flush) begin
        if ((r_state == BUSY) || (r_state == FIX)) begin
          r_rv_valid <= 1'b0;
        end
      end else if (r_state == FIX) begin
        r_rv_valid <= 1'b1;
        r_rv_cls   <= op_class(r_op);
        r_rv_a     <= r_a_raw;
        r_rv_b     <= r_b_raw;
        r_rv_hi    <= w_fix_hi;
        r_rv_lo    <= w_fix_lo;
      end else if (w_accept && w_special && (op_class(w_op) != r_rv_cls)) begin
        r_rv_valid <= 1'b0;
      end
    end
  end
`else
  assign w_hit     = 1'b0;
  assign w_hit_val = ZERO;
`endif

  // Output presentation; o_result is forced to zero outside the done pulse
  always_comb begin
    o_stall = w_stall;
    o_done  = (r_state == DONE) && !i_flush;
    if (o_done) begin
      o_result = r_result;
    end else begin
      o_result = ZERO;
    end
  end

endmodule
